// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin mux arbiter.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       forced;

  modport master (
    input  req,
    output gnt,
    output sel,
    output busy,
    output forced
  );

  modport slave (
    output req,
    input  gnt,
    input  sel,
    input  busy,
    input  forced
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbitration for a shared 4:1 single-bit mux, with an
// optional fairness timeout that revokes a long-held grant when others wait.
module mux4_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CW       = 8
) (
  input  logic              clk,
  input  logic              rst,
  mux4_rr_arbiter_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CW-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CW'(HOLD_MAX - 1);

  state_t      state;
  logic [3:0]  gnt_q;
  logic [1:0]  own;
  logic [1:0]  ptr;
  logic [CW-1:0] count;
  logic        busy_q;
  logic        forced_q;

  logic [1:0]  pick;
  logic [1:0]  cand;
  logic        found;
  logic        others;

  // First requester at or after ptr, wrapping mod 4.
  always_comb begin
    pick  = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign others = |(bus.req & ~(4'b0001 << own));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= '0;
      own      <= '0;
      ptr      <= '0;
      count    <= '0;
      busy_q   <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      forced_q <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state  <= GRANT;
            gnt_q  <= 4'b0001 << pick;
            own    <= pick;
            ptr    <= pick + 2'd1;
            count  <= '0;
            busy_q <= 1'b1;
          end
        end
        GRANT: begin
          // Release wins over a coincident timeout, so forced stays low.
          if (!bus.req[own]) begin
            state  <= IDLE;
            gnt_q  <= '0;
            busy_q <= 1'b0;
          end else if (HOLD_MAX != 0 && count == HOLD_LAST && others) begin
            state    <= IDLE;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            forced_q <= 1'b1;
          end else if (HOLD_MAX != 0 && count != HOLD_LAST) begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          gnt_q  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.sel    = own;
  assign bus.busy   = busy_q;
  assign bus.forced = forced_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed-vector bench for mux4_rr_arbiter with hand-computed expectations.
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst;
  int unsigned n_vec;
  int unsigned n_bad;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(
    .HOLD_MAX(8),
    .CW      (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive req, let one rising edge sample it, return on the following falling edge.
  task automatic tick(input logic [3:0] r);
    bus.req = r;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                            input logic b, input logic f);
    chk({tag, "_gnt"},    8'(bus.gnt),    8'(g));
    chk({tag, "_sel"},    8'(bus.sel),    8'(s));
    chk({tag, "_busy"},   8'(bus.busy),   8'(b));
    chk({tag, "_forced"}, 8'(bus.forced), 8'(f));
  endtask

  always @(negedge clk) begin
    chk("inv_onehot0", 8'($onehot0(bus.gnt)), 8'd1);
    chk("inv_busy",    8'(bus.busy), 8'(|bus.gnt));
    if (bus.busy)   chk("inv_gnt_sel", 8'(bus.gnt[bus.sel]), 8'd1);
    if (bus.forced) chk("inv_forced",  8'(bus.gnt), 8'd0);
  end

  initial begin
    logic [3:0] all;
    logic [3:0] oh;
    n_vec   = 0;
    n_bad   = 0;
    all     = 4'b1111;
    rst     = 1'b1;
    bus.req = '0;

    // Reset state, single request, release, pointer advanced to 3.
    tick(4'b0000);
    rst = 1'b0;
    expect_out("rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(4'b0100);
    expect_out("g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick(4'b0000);
    expect_out("rel2", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick(4'b1111);
    expect_out("ptr3", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick(4'b0000);
    expect_out("rel3", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Full rotation 0,1,2,3,0 from ptr=0 with one idle cycle between owners.
    for (int o = 0; o < 5; o++) begin
      oh = 4'b0001 << (o % 4);
      tick(all);
      expect_out("rot_a", oh, 2'(o % 4), 1'b1, 1'b0);
      tick(all);
      expect_out("rot_b", oh, 2'(o % 4), 1'b1, 1'b0);
      tick(all & ~oh);
      expect_out("rot_gap", 4'b0000, 2'(o % 4), 1'b0, 1'b0);
    end

    // Timeout: owner 0 holds, requester 1 waits.
    rst = 1'b1;
    tick(4'b0000);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick(4'b0011);
      expect_out("hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick(4'b0011);
    expect_out("timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick(4'b0011);
    expect_out("after_to", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick(4'b0000);
    expect_out("rel_to", 4'b0000, 2'd1, 1'b0, 1'b0);

    // Lone requester is never timed out.
    for (int c = 0; c < 20; c++) begin
      tick(4'b0100);
      expect_out("lone", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    tick(4'b0000);
    expect_out("rel_lone", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Reset mid-grant clears the pointer as well.
    tick(4'b1000);
    expect_out("g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    rst = 1'b1;
    tick(4'b1001);
    expect_out("midrst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(4'b1001);
    expect_out("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick(4'b0000);
    expect_out("rel_post", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Release on the eighth grant cycle with others pending: not forced.
    for (int c = 0; c < 8; c++) begin
      tick(4'b0110);
      expect_out("hold1", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick(4'b0100);
    expect_out("rel_vs_to", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick(4'b0100);
    expect_out("next2", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick(4'b0000);
    expect_out("rel_end", 4'b0000, 2'd2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 single-bit mux datapath among four requesters.
- Each requester i drives mux input in[i]. The arbiter drives the mux 2-bit select and a one-hot grant, and holds ownership until the owner releases or a fairness timeout expires.
- Sits directly in front of the 4:1 mux. Its sel output connects to the mux sel input.

Parameters:
- HOLD_MAX, 8, maximum consecutive GRANT cycles for one owner while another requester waits. 0 means no limit. Legal range 0..255.
- CW, 8, width of the hold counter. Must satisfy 2^CW > HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  request vector; req[i] is held high by requester i while it wants the mux
- gnt  output 4  one-hot grant, or all-zero; registered
- sel  output 2  mux select = index of granted requester; registered; holds last value when gnt==0
- busy  output 1  high while in GRANT state (equals |gnt)
- forced  output 1  single-cycle pulse on the cycle a grant is revoked by timeout

Behaviour:
- Reset: at a rising clk edge with rst=1, state=IDLE, gnt=4'b0000, sel=2'b00, busy=0, forced=0, ptr=2'b00, hold count=0. Reset applies in any state, mid-grant included, and takes effect at the edge with no drain cycle.
- States: IDLE, GRANT. Owner index own[1:0] is registered and equals sel.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first i with req[i]=1 in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next cycle: state=GRANT, gnt=1<<i, sel=i, ptr=i+1 mod 4, count=0.
  - Request-to-grant latency is exactly 1 cycle.
- GRANT, normal release: if req[own]=0, next cycle state=IDLE, gnt=0, and sel keeps its value.
- GRANT, timeout: if HOLD_MAX!=0, count==HOLD_MAX-1, and any other req bit is high, revoke the grant.
  - Next cycle: state=IDLE, gnt=0, forced=1 for that one cycle.
- GRANT, otherwise: stay in GRANT. count increments and saturates at HOLD_MAX-1. When no other requester is pending, the owner keeps the grant indefinitely.
- Simultaneous release and timeout: treat as a normal release, so forced stays 0.
- Between any two grants there is exactly one cycle with gnt=0. Back-to-back grants without a gap are never issued.
- Requests arriving or dropping while another requester owns the grant have no effect until the next IDLE cycle. A requester that drops req before being granted is simply skipped.
- Rotation wrap-around: ptr rolls from 3 to 0. Priority order is strictly rotating, with no fixed-priority fallback.
- Invariants, checked every cycle:
  - gnt is onehot0.
  - busy==|gnt.
  - When busy=1, gnt[sel]=1.
  - forced implies gnt==0.
- X handling: req is sampled only at the clk edge. Outputs come directly from flops, with no combinational path from req.

Test Plan:
- Reset then req=4'b0100 from cycle 2 -> gnt=4'b0100, sel=2 at cycle 3; ptr=3; drop req -> gnt=0 next cycle, sel stays 2.
- From ptr=0, req=4'b1111 held constant, each owner dropping req for 1 cycle after 2 grant cycles -> grant order 0,1,2,3,0; one gnt=0 cycle between each.
- HOLD_MAX=8: req=4'b0011, owner 0 never releases -> gnt=4'b0001 for exactly 8 cycles, then gnt=0 with forced=1 for one cycle, then gnt=4'b0010.
- HOLD_MAX=8: only req[2] high for 20 cycles -> gnt=4'b0100 for all 20 cycles, forced never asserts.
- Assert rst for 1 cycle while gnt=4'b1000 -> next cycle gnt=0, sel=0, busy=0; with req=4'b1001 afterwards, the next grant is index 0 because ptr was reset to 0.
- Release and timeout in the same cycle (owner drops req on its 8th grant cycle, others pending) -> gnt=0, forced=0.
